// File: rtl/dut_8bit_adder_expand.sv
// Registered 8-bit adder with carry-in and optional programmable offset,
// plus a small descriptor-port register file (CTRL/OFFSET/SCRATCH/LAST_SUM/STATUS).
module dut_8bit_adder_expand (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Data_val,
    input  logic [7:0] Value_a,
    input  logic [7:0] Value_b,
    input  logic       c_in,
    input  logic [2:0] Des_address,
    input  logic [7:0] Des_value,
    input  logic       Des_req_valid,
    input  logic       Des_wr_rd,
    output logic [7:0] Sum_result,
    output logic       Sum_carry,
    output logic       Data_ready,
    output logic [7:0] Des_rd_value
);

    // Handshake: Data_val qualifies operands on each rising edge and is always
    // accepted (no back-pressure); Data_ready is high for exactly the cycle after
    // an accepted add. Des_req_valid is likewise always accepted in one cycle.
    // reset_n is active-high despite its name.

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_OFFSET  = 3'd1;
    localparam logic [2:0] ADDR_SCRATCH = 3'd2;
    localparam logic [2:0] ADDR_LASTSUM = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;

    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] offset_q, offset_d;
    logic [7:0] scratch_q, scratch_d;
    logic       sticky_q, sticky_d;
    logic [7:0] sum_result_q, sum_result_d;
    logic       sum_carry_q, sum_carry_d;
    logic       data_ready_q, data_ready_d;
    logic [7:0] rd_value_q, rd_value_d;

    logic [9:0] total;
    logic [9:0] offset_term;
    logic       total_carry;
    logic       des_wr;
    logic       des_rd;
    logic [7:0] rd_mux;

    always_comb begin
        offset_term = ctrl_q[0] ? {2'b00, offset_q} : 10'd0;
        total       = {2'b00, Value_a} + {2'b00, Value_b} + {9'd0, c_in} + offset_term;
        total_carry = |total[9:8];
        des_wr      = Des_req_valid & Des_wr_rd;
        des_rd      = Des_req_valid & ~Des_wr_rd;

        // Read mux always sees pre-edge contents, so same-edge writes/adds read old data.
        case (Des_address)
            ADDR_CTRL:    rd_mux = ctrl_q;
            ADDR_OFFSET:  rd_mux = offset_q;
            ADDR_SCRATCH: rd_mux = scratch_q;
            ADDR_LASTSUM: rd_mux = sum_result_q;
            ADDR_STATUS:  rd_mux = {6'd0, sticky_q, sum_carry_q};
            default:      rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        offset_d     = offset_q;
        scratch_d    = scratch_q;
        sticky_d     = sticky_q;
        sum_result_d = sum_result_q;
        sum_carry_d  = sum_carry_q;
        data_ready_d = 1'b0;
        rd_value_d   = rd_value_q;

        if (des_wr) begin
            case (Des_address)
                ADDR_CTRL:    ctrl_d    = Des_value;
                ADDR_OFFSET:  offset_d  = Des_value;
                ADDR_SCRATCH: scratch_d = Des_value;
                ADDR_STATUS:  sticky_d  = 1'b0;
                default:      ;
            endcase
        end

        if (des_rd) begin
            rd_value_d = rd_mux;
        end

        // A carry on the same edge as a STATUS write wins: the new event stays visible.
        if (Data_val) begin
            sum_result_d = total[7:0];
            sum_carry_d  = total_carry;
            data_ready_d = 1'b1;
            if (total_carry) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            ctrl_q       <= 8'h00;
            offset_q     <= 8'h00;
            scratch_q    <= 8'h00;
            sticky_q     <= 1'b0;
            sum_result_q <= 8'h00;
            sum_carry_q  <= 1'b0;
            data_ready_q <= 1'b0;
            rd_value_q   <= 8'h00;
        end else begin
            ctrl_q       <= ctrl_d;
            offset_q     <= offset_d;
            scratch_q    <= scratch_d;
            sticky_q     <= sticky_d;
            sum_result_q <= sum_result_d;
            sum_carry_q  <= sum_carry_d;
            data_ready_q <= data_ready_d;
            rd_value_q   <= rd_value_d;
        end
    end

    assign Sum_result   = sum_result_q;
    assign Sum_carry    = sum_carry_q;
    assign Data_ready   = data_ready_q;
    assign Des_rd_value = rd_value_q;

endmodule

// File: tb/tb_dut_8bit_adder_expand.sv
// Directed bench for dut_8bit_adder_expand: hand-computed vectors checked with
// immediate assertions, one linear stimulus sequence.
module tb_dut_8bit_adder_expand;

    logic       clk;
    logic       rst;
    logic       data_val;
    logic [7:0] value_a;
    logic [7:0] value_b;
    logic       c_in;
    logic [2:0] des_address;
    logic [7:0] des_value;
    logic       des_req_valid;
    logic       des_wr_rd;
    logic [7:0] sum_result;
    logic       sum_carry;
    logic       data_ready;
    logic [7:0] des_rd_value;

    int n_checks = 0;
    int n_fail   = 0;

    dut_8bit_adder_expand u_dut (
        .clk          (clk),
        .reset_n      (rst),
        .Data_val     (data_val),
        .Value_a      (value_a),
        .Value_b      (value_b),
        .c_in         (c_in),
        .Des_address  (des_address),
        .Des_value    (des_value),
        .Des_req_valid(des_req_valid),
        .Des_wr_rd    (des_wr_rd),
        .Sum_result   (sum_result),
        .Sum_carry    (sum_carry),
        .Data_ready   (data_ready),
        .Des_rd_value (des_rd_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sampling point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_add(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        data_val = v;
        value_a  = a;
        value_b  = b;
        c_in     = c;
    endtask

    task automatic set_des(input logic req, input logic wr, input logic [2:0] addr, input logic [7:0] val);
        des_req_valid = req;
        des_wr_rd     = wr;
        des_address   = addr;
        des_value     = val;
    endtask

    initial begin
        rst = 1'b1;
        set_add(1'b0, 8'h00, 8'h00, 1'b0);
        set_des(1'b0, 1'b0, 3'd0, 8'h00);
        repeat (3) tick();
        chk("rst_sum", sum_result, 8'h00);
        chk("rst_carry", {7'd0, sum_carry}, 8'h00);
        chk("rst_ready", {7'd0, data_ready}, 8'h00);
        chk("rst_rd", des_rd_value, 8'h00);
        rst = 1'b0;

        // Basic add with carry-out
        set_add(1'b1, 8'hFF, 8'h07, 1'b0);
        tick();
        chk("add1_sum", sum_result, 8'h06);
        chk("add1_carry", {7'd0, sum_carry}, 8'h01);
        chk("add1_ready", {7'd0, data_ready}, 8'h01);

        // OFFSET write, then CTRL write on the same edge as an add
        set_add(1'b0, 8'h00, 8'h00, 1'b0);
        set_des(1'b1, 1'b1, 3'd1, 8'h0E);
        tick();
        chk("idle_ready", {7'd0, data_ready}, 8'h00);
        chk("idle_sum_hold", sum_result, 8'h06);
        set_des(1'b1, 1'b1, 3'd0, 8'h01);
        set_add(1'b1, 8'h01, 8'h0F, 1'b0);
        tick();
        chk("ctrl_same_edge_sum", sum_result, 8'h10);
        chk("ctrl_same_edge_carry", {7'd0, sum_carry}, 8'h00);
        set_des(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        chk("offset_sum", sum_result, 8'h1E);
        chk("offset_carry", {7'd0, sum_carry}, 8'h00);

        // Read OFFSET with Data_val low, then hold
        set_add(1'b0, 8'hAA, 8'h55, 1'b1);
        set_des(1'b1, 1'b0, 3'd1, 8'h77);
        tick();
        chk("rd_offset", des_rd_value, 8'h0E);
        chk("dv0_ready", {7'd0, data_ready}, 8'h00);
        chk("dv0_sum_hold", sum_result, 8'h1E);
        chk("dv0_carry_hold", {7'd0, sum_carry}, 8'h00);
        set_des(1'b0, 1'b0, 3'd5, 8'h00);
        tick();
        chk("rd_hold", des_rd_value, 8'h0E);

        // Reserved addresses: write ignored, read zero
        set_des(1'b1, 1'b1, 3'd5, 8'hFF);
        tick();
        set_des(1'b1, 1'b0, 3'd5, 8'h00);
        tick();
        chk("rd_res5", des_rd_value, 8'h00);
        set_des(1'b1, 1'b0, 3'd1, 8'h00);
        tick();
        set_des(1'b1, 1'b0, 3'd6, 8'h00);
        tick();
        chk("rd_res6", des_rd_value, 8'h00);
        set_des(1'b1, 1'b0, 3'd1, 8'h00);
        tick();
        set_des(1'b1, 1'b0, 3'd7, 8'h00);
        tick();
        chk("rd_res7", des_rd_value, 8'h00);

        // CTRL upper bits and SCRATCH store; same-edge read/write returns old
        set_des(1'b1, 1'b1, 3'd0, 8'hA5);
        tick();
        set_des(1'b1, 1'b0, 3'd0, 8'h00);
        tick();
        chk("rd_ctrl", des_rd_value, 8'hA5);
        set_des(1'b1, 1'b1, 3'd2, 8'h5A);
        tick();
        set_des(1'b1, 1'b0, 3'd2, 8'h00);
        tick();
        chk("rd_scratch", des_rd_value, 8'h5A);

        // Offset-enabled add after idle cycles
        set_des(1'b0, 1'b0, 3'd0, 8'h00);
        set_add(1'b1, 8'h10, 8'h0C, 1'b0);
        tick();
        chk("add_off_sum", sum_result, 8'h2A);
        chk("add_off_ready", {7'd0, data_ready}, 8'h01);

        // Maximum total: 0xFF+0xFF+1+0xFF = 0x2FE
        set_add(1'b0, 8'h00, 8'h00, 1'b0);
        set_des(1'b1, 1'b1, 3'd1, 8'hFF);
        tick();
        set_des(1'b0, 1'b0, 3'd0, 8'h00);
        set_add(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        chk("max_sum", sum_result, 8'hFE);
        chk("max_carry", {7'd0, sum_carry}, 8'h01);
        set_add(1'b0, 8'h00, 8'h00, 1'b0);
        set_des(1'b1, 1'b0, 3'd4, 8'h00);
        tick();
        chk("status_both", des_rd_value, 8'h03);
        set_des(1'b1, 1'b0, 3'd3, 8'h00);
        tick();
        chk("rd_lastsum", des_rd_value, 8'hFE);

        // Sticky survives a carry-free sum, cleared by writing address 4
        set_des(1'b1, 1'b1, 3'd0, 8'h00);
        tick();
        set_des(1'b0, 1'b0, 3'd0, 8'h00);
        set_add(1'b1, 8'h01, 8'h02, 1'b0);
        tick();
        chk("nocarry_sum", sum_result, 8'h03);
        set_add(1'b0, 8'h00, 8'h00, 1'b0);
        set_des(1'b1, 1'b0, 3'd4, 8'h00);
        tick();
        chk("status_sticky", des_rd_value, 8'h02);
        set_des(1'b1, 1'b1, 3'd4, 8'h3C);
        tick();
        set_des(1'b1, 1'b0, 3'd4, 8'h00);
        tick();
        chk("status_cleared", des_rd_value, 8'h00);

        // Same-edge add and LAST_SUM read: read sees pre-edge sum
        set_add(1'b1, 8'h20, 8'h01, 1'b0);
        set_des(1'b1, 1'b0, 3'd3, 8'h00);
        tick();
        chk("lastsum_same_edge_rd", des_rd_value, 8'h03);
        chk("lastsum_same_edge_sum", sum_result, 8'h21);

        // Mid-stream asynchronous reset
        set_des(1'b1, 1'b1, 3'd0, 8'h01);
        set_add(1'b1, 8'h80, 8'h01, 1'b0);
        tick();
        set_des(1'b1, 1'b0, 3'd2, 8'h00);
        set_add(1'b1, 8'h40, 8'h02, 1'b1);
        tick();
        chk("pre_rst_rd", des_rd_value, 8'h5A);
        chk("pre_rst_ready", {7'd0, data_ready}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sum", sum_result, 8'h00);
        chk("async_rst_ready", {7'd0, data_ready}, 8'h00);
        chk("async_rst_rd", des_rd_value, 8'h00);
        chk("async_rst_carry", {7'd0, sum_carry}, 8'h00);
        set_add(1'b0, 8'h00, 8'h00, 1'b0);
        set_des(1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        rst = 1'b0;

        set_des(1'b1, 1'b0, 3'd2, 8'h00);
        tick();
        chk("post_rst_scratch", des_rd_value, 8'h00);
        set_des(1'b1, 1'b0, 3'd0, 8'h00);
        tick();
        chk("post_rst_ctrl", des_rd_value, 8'h00);
        set_des(1'b1, 1'b0, 3'd1, 8'h00);
        tick();
        chk("post_rst_offset", des_rd_value, 8'h00);

        // Offset must be disabled after reset: plain sum
        set_des(1'b0, 1'b0, 3'd0, 8'h00);
        set_add(1'b1, 8'h33, 8'h44, 1'b1);
        tick();
        chk("post_rst_add", sum_result, 8'h78);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dut_8bit_adder_expand.md
# dut_8bit_adder_expand

Registered 8-bit adder with carry-in and a small register file, reached through a simple request/write/read port. A programmable offset can be added to every sum when enabled in a control register. The block sits between a data-producing stage (operands + valid) and a consumer of sums, with configuration traffic on a separate descriptor port.

## Interface
- No parameters; all widths fixed.
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous reset, active-high: while 1, all state is held at reset values. The port name is the codebase's; the polarity is high.
- Data_val  in  1  operands valid this cycle.
- Value_a  in  8  operand A, unsigned.
- Value_b  in  8  operand B, unsigned.
- c_in  in  1  carry-in.
- Des_address  in  3  register address.
- Des_value  in  8  register write data.
- Des_req_valid  in  1  register request strobe.
- Des_wr_rd  in  1  1 = write, 0 = read.
- Sum_result  out  8  registered sum, low 8 bits.
- Sum_carry  out  1  registered carry-out / overflow flag.
- Data_ready  out  1  Sum_result/Sum_carry updated at the last edge.
- Des_rd_value  out  8  registered read data.

## Operation
- Register map (Des_address):
  - 0 CTRL, R/W, reset 0x00. Bit0 = OFFSET_EN; bits 7:1 stored and read back, no function.
  - 1 OFFSET, R/W, reset 0x00. Unsigned 8-bit offset.
  - 2 SCRATCH, R/W, reset 0x00. General-purpose, no function.
  - 3 LAST_SUM, RO, mirrors Sum_result.
  - 4 STATUS, RO: bit0 = Sum_carry, bit1 = sticky carry (set on any sum with carry, cleared only by reset or by writing any value to address 4), bits 7:2 = 0.
  - 5..7 reserved: writes ignored, reads return 0x00.
- Add: on an edge with Data_val = 1, compute T = Value_a + Value_b + c_in + (OFFSET_EN ? OFFSET : 0) as a 10-bit unsigned value (max 766). Sum_result <= T[7:0]; Sum_carry <= (T > 255). Data_ready <= 1.
- On an edge with Data_val = 0: Data_ready <= 0; Sum_result and Sum_carry hold.
- Write: on an edge with Des_req_valid = 1 and Des_wr_rd = 1, the addressed R/W register takes Des_value. Writes to RO addresses have no effect except the STATUS sticky clear.
- Read: on an edge with Des_req_valid = 1 and Des_wr_rd = 0, Des_rd_value <= addressed register value (pre-edge contents). Otherwise Des_rd_value holds.
- Des_value is ignored on reads; operand inputs are ignored when Data_val = 0.

## Timing
- Reset values: Sum_result 0x00, Sum_carry 0, Data_ready 0, Des_rd_value 0x00, all registers 0x00, sticky 0.
- Add latency: 1 cycle; outputs change only on clk rising edge (or reset).
- Data_val held high for N cycles -> Data_ready high for N cycles, a new sum each cycle (full throughput, no back-pressure).
- Read latency: 1 cycle; Des_rd_value holds until the next read.
- Same-edge add and write of CTRL/OFFSET: the add uses the pre-write values; the new value applies from the following edge.
- Same-edge read and write (any address): read returns the old value.
- Same-edge add and read of LAST_SUM/STATUS: read returns the pre-edge value.
- Reset asserted mid-operation: all outputs and registers return to reset values immediately (asynchronous), without waiting for a clock edge; an in-flight add or register write is discarded.

## Test plan
- Reset held, then released; Data_val = 1, A = 0xFF, B = 0x07, c_in = 0, CTRL = 0 -> next edge Sum_result = 0x06, Sum_carry = 1, Data_ready = 1.
- Write OFFSET = 0x0E, then CTRL = 0x01; add A = 0x01, B = 0x0F, c_in = 0 -> Sum_result = 0x1E, Sum_carry = 0; in the same cycle as the CTRL write, the add still excludes the offset.
- Read address 1 after the write above -> Des_rd_value = 0x0E one edge later and holds; reads of addresses 5–7 -> 0x00.
- Data_val = 0 for one cycle -> Data_ready = 0, Sum_result/Sum_carry unchanged; Data_val = 1 the next cycle with A = 0x10, B = 0x0C, offset enabled (0x0E) -> Sum_result = 0x2A.
- OFFSET = 0xFF, CTRL = 1, A = 0xFF, B = 0xFF, c_in = 1 -> Sum_result = 0xFE, Sum_carry = 1; STATUS read = 0x03; write address 4, read STATUS -> sticky bit cleared.
- Assert reset mid-stream -> all outputs go to 0 without a clock edge; CTRL, OFFSET and SCRATCH read back 0x00 after release.
